// File: rtl/ram_if.sv
//------------------------------------------------------------------------------
// Module   : ram_if
// Brief    : Word-wide RAM request/response bundle between a bus initiator
//            (memory arbiter / testbench) and the RAM responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_if;
  // Request side: REN/WEN are held by the initiator until ACCESS or ERROR.
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  // Response side: ramstate encodes FREE=0, BUSY=1, ACCESS=2, ERROR=3.
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate
  );
endinterface

`default_nettype wire

// File: rtl/ram_responder.sv
//------------------------------------------------------------------------------
// Module   : ram_responder
// Brief    : Memory-side responder with a fixed programmable latency. Accepts
//            one word read or write at a time, reports BUSY for LAT cycles,
//            then ACCESS for one cycle; illegal requests report ERROR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_responder #(
  parameter int LAT   = 2,     // BUSY cycles before ACCESS, 1..15
  parameter int DEPTH = 1024   // storage size in 32-bit words
) (
  input  wire logic clk,
  input  wire logic rst,
  ram_if.slave      bus
);

  localparam int          C_IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] C_DEPTH    = 33'(DEPTH);
  localparam logic [3:0]  C_CNT_INIT = 4'(LAT - 1);

  // Response status encoding seen on ramstate
  localparam logic [1:0] C_FREE   = 2'd0;
  localparam logic [1:0] C_BUSY   = 2'd1;
  localparam logic [1:0] C_ACCESS = 2'd2;
  localparam logic [1:0] C_ERROR  = 2'd3;

  // Controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_status;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic        r_wr;
  logic [31:0] r_load;
  logic [31:0] r_mem [DEPTH];

  logic              w_one;
  logic              w_both;
  logic              w_none;
  logic              w_aligned;
  logic              w_in_range;
  logic              w_legal;
  logic              w_same;
  logic              w_fire;
  logic [C_IDXW-1:0] w_idx;

  // Request classification against the live bus and the latched request
  assign w_one      = bus.ramREN ^ bus.ramWEN;
  assign w_both     = bus.ramREN & bus.ramWEN;
  assign w_none     = ~(bus.ramREN | bus.ramWEN);
  assign w_aligned  = (bus.ramaddr[1:0] == 2'b00);
  assign w_in_range = ({3'b000, bus.ramaddr[31:2]} < C_DEPTH);
  assign w_legal    = w_one & w_aligned & w_in_range;
  assign w_same     = (bus.ramaddr == r_addr) && (bus.ramWEN == r_wr);

  // The memory operation happens on the edge that leaves WAIT for ACC: the
  // request is still steady and the latency counter has run out.
  assign w_fire = (r_state == S_WAIT) && w_one && w_same && (r_cnt == 4'd0);
  assign w_idx  = r_addr[C_IDXW+1:2];

  // Request controller: latch, latency countdown, abort/restart and status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_status <= C_FREE;
      r_cnt    <= 4'd0;
      r_addr   <= 32'd0;
      r_store  <= 32'd0;
      r_wr     <= 1'b0;
      r_load   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_addr   <= bus.ramaddr;
            r_store  <= bus.ramstore;
            r_wr     <= bus.ramWEN;
            r_cnt    <= C_CNT_INIT;
            r_state  <= S_WAIT;
            r_status <= C_BUSY;
          end else if (!w_none) begin
            r_state  <= S_ERR;
            r_status <= C_ERROR;
          end
        end

        S_WAIT: begin
          if (w_both) begin
            r_state  <= S_ERR;
            r_status <= C_ERROR;
          end else if (w_none) begin
            r_state  <= S_IDLE;
            r_status <= C_FREE;
          end else if (!w_same) begin
            // A changed request restarts the full latency; a changed request
            // that is itself illegal is reported as an error instead.
            if (w_legal) begin
              r_addr  <= bus.ramaddr;
              r_store <= bus.ramstore;
              r_wr    <= bus.ramWEN;
              r_cnt   <= C_CNT_INIT;
            end else begin
              r_state  <= S_ERR;
              r_status <= C_ERROR;
            end
          end else if (r_cnt == 4'd0) begin
            r_state  <= S_ACC;
            r_status <= C_ACCESS;
            if (!r_wr) begin
              r_load <= r_mem[w_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_ACC, S_ERR: begin
          r_state  <= S_IDLE;
          r_status <= C_FREE;
        end

        default: begin
          r_state  <= S_IDLE;
          r_status <= C_FREE;
        end
      endcase
    end
  end

  // Backing store: cleared on reset, written only on a write completion
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_fire && r_wr) begin
      r_mem[w_idx] <= r_store;
    end
  end

  assign bus.ramload  = r_load;
  assign bus.ramstate = r_status;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_responder
// Brief    : Directed self-checking bench for ram_responder (LAT=2 main
//            instance, plus LAT=1 and LAT=15 instances for latency checks).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure request spacing
  always @(posedge clk) cyc <= cyc + 1;

  ram_if bus();
  ram_if bus1();
  ram_if bus15();

  // Drivers for the two latency-variant instances, indexed 0 = LAT1, 1 = LAT15
  logic        a_ren   [2];
  logic        a_wen   [2];
  logic [31:0] a_addr  [2];
  logic [31:0] a_store [2];

  assign bus1.ramREN    = a_ren[0];
  assign bus1.ramWEN    = a_wen[0];
  assign bus1.ramaddr   = a_addr[0];
  assign bus1.ramstore  = a_store[0];
  assign bus15.ramREN   = a_ren[1];
  assign bus15.ramWEN   = a_wen[1];
  assign bus15.ramaddr  = a_addr[1];
  assign bus15.ramstore = a_store[1];

  ram_responder #(.LAT(2),  .DEPTH(1024)) dut   (.clk(clk), .rst(rst), .bus(bus));
  ram_responder #(.LAT(1),  .DEPTH(1024)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
  ram_responder #(.LAT(15), .DEPTH(1024)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

  function automatic logic [1:0] aux_state(input int k);
    return (k == 0) ? bus1.ramstate : bus15.ramstate;
  endfunction

  function automatic logic [31:0] aux_load(input int k);
    return (k == 0) ? bus1.ramload : bus15.ramload;
  endfunction

  // Drive one request on the main bus and follow it to ACCESS/ERROR, then drop
  // it and sample the state one edge later. Bounded to 40 edges.
  task automatic run_op(input bit ren, input bit wen, input logic [31:0] addr,
                        input logic [31:0] data, output int nbusy,
                        output logic [1:0] fin, output logic [31:0] ld,
                        output logic [1:0] after);
    nbusy = 0;
    fin   = FREE;
    ld    = 32'hx;
    bus.ramREN   = ren;
    bus.ramWEN   = wen;
    bus.ramaddr  = addr;
    bus.ramstore = data;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ramstate == BUSY) nbusy++;
      else if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
        fin = bus.ramstate;
        ld  = bus.ramload;
        break;
      end else if (nbusy > 0) break;
    end
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    @(posedge clk); #1;
    after = bus.ramstate;
  endtask

  task automatic aux_op(input int k, input bit wen, input logic [31:0] addr,
                        input logic [31:0] data, output int nbusy,
                        output logic [1:0] fin, output logic [31:0] ld);
    nbusy = 0;
    fin   = FREE;
    ld    = 32'hx;
    a_ren[k]   = ~wen;
    a_wen[k]   = wen;
    a_addr[k]  = addr;
    a_store[k] = data;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (aux_state(k) == BUSY) nbusy++;
      else if (aux_state(k) == ACCESS || aux_state(k) == ERROR) begin
        fin = aux_state(k);
        ld  = aux_load(k);
        break;
      end else if (nbusy > 0) break;
    end
    a_ren[k] = 1'b0;
    a_wen[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.ramstate !== FREE) begin bad++; $display("FAIL reset_state: got=%0d exp=%0d", bus.ramstate, FREE); end
    total++; if (bus.ramload !== 32'd0) begin bad++; $display("FAIL reset_load: got=%h exp=00000000", bus.ramload); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ramstate !== FREE) begin bad++; $display("FAIL idle_state: got=%0d exp=%0d", bus.ramstate, FREE); end
  endtask

  task automatic test_write_read();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    run_op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, nb, fin, ld, aft);
    total++; if (nb !== 2) begin bad++; $display("FAIL wr_busy: got=%0d exp=2", nb); end
    total++; if (fin !== ACCESS) begin bad++; $display("FAIL wr_fin: got=%0d exp=%0d", fin, ACCESS); end
    total++; if (aft !== FREE) begin bad++; $display("FAIL wr_after: got=%0d exp=%0d", aft, FREE); end
    run_op(1'b1, 1'b0, 32'h40, 32'h0, nb, fin, ld, aft);
    total++; if (nb !== 2) begin bad++; $display("FAIL rd_busy: got=%0d exp=2", nb); end
    total++; if (fin !== ACCESS) begin bad++; $display("FAIL rd_fin: got=%0d exp=%0d", fin, ACCESS); end
    total++; if (ld !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_load: got=%h exp=deadbeef", ld); end
    total++; if (aft !== FREE) begin bad++; $display("FAIL rd_after: got=%0d exp=%0d", aft, FREE); end
    total++; if (bus.ramload !== 32'hDEADBEEF) begin bad++; $display("FAIL load_hold: got=%h exp=deadbeef", bus.ramload); end
  endtask

  task automatic test_unwritten_and_reset();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    run_op(1'b1, 1'b0, 32'h100, 32'h0, nb, fin, ld, aft);
    total++; if (fin !== ACCESS) begin bad++; $display("FAIL unwr_fin: got=%0d exp=%0d", fin, ACCESS); end
    total++; if (ld !== 32'd0) begin bad++; $display("FAIL unwr_load: got=%h exp=00000000", ld); end
    // Reload DEADBEEF so the reset clearing ramload is visible
    run_op(1'b1, 1'b0, 32'h40, 32'h0, nb, fin, ld, aft);
    // Start a write, then reset during the first BUSY cycle
    bus.ramWEN = 1'b1; bus.ramaddr = 32'h48; bus.ramstore = 32'h5555AAAA;
    @(posedge clk); #1;
    total++; if (bus.ramstate !== BUSY) begin bad++; $display("FAIL rst_pre: got=%0d exp=%0d", bus.ramstate, BUSY); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.ramWEN = 1'b0;
    total++; if (bus.ramstate !== FREE) begin bad++; $display("FAIL rst_mid_state: got=%0d exp=%0d", bus.ramstate, FREE); end
    total++; if (bus.ramload !== 32'd0) begin bad++; $display("FAIL rst_mid_load: got=%h exp=00000000", bus.ramload); end
    repeat (4) @(posedge clk);
    #1;
    run_op(1'b1, 1'b0, 32'h48, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'd0) begin bad++; $display("FAIL rst_nowrite: got=%h exp=00000000", ld); end
    run_op(1'b1, 1'b0, 32'h40, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'd0) begin bad++; $display("FAIL rst_clear: got=%h exp=00000000", ld); end
  endtask

  task automatic test_errors();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    run_op(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, nb, fin, ld, aft);
    run_op(1'b1, 1'b1, 32'h8, 32'h11111111, nb, fin, ld, aft);
    total++; if (nb !== 0) begin bad++; $display("FAIL both_busy: got=%0d exp=0", nb); end
    total++; if (fin !== ERROR) begin bad++; $display("FAIL both_fin: got=%0d exp=%0d", fin, ERROR); end
    total++; if (aft !== FREE) begin bad++; $display("FAIL both_after: got=%0d exp=%0d", aft, FREE); end
    run_op(1'b0, 1'b1, 32'h6, 32'h22222222, nb, fin, ld, aft);
    total++; if (fin !== ERROR) begin bad++; $display("FAIL misal_fin: got=%0d exp=%0d", fin, ERROR); end
    run_op(1'b0, 1'b1, 32'h1000, 32'h33333333, nb, fin, ld, aft);
    total++; if (fin !== ERROR) begin bad++; $display("FAIL range_fin: got=%0d exp=%0d", fin, ERROR); end
    total++; if (nb !== 0) begin bad++; $display("FAIL range_busy: got=%0d exp=0", nb); end
    run_op(1'b1, 1'b0, 32'h8, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'hCAFEF00D) begin bad++; $display("FAIL err_mem8: got=%h exp=cafef00d", ld); end
    run_op(1'b1, 1'b0, 32'h4, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'd0) begin bad++; $display("FAIL err_mem4: got=%h exp=00000000", ld); end
    run_op(1'b1, 1'b0, 32'h0, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'd0) begin bad++; $display("FAIL err_mem0: got=%h exp=00000000", ld); end
  endtask

  task automatic test_abort();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    int seen_acc;
    run_op(1'b0, 1'b1, 32'h20, 32'h0BADF00D, nb, fin, ld, aft);
    bus.ramWEN = 1'b1; bus.ramaddr = 32'h20; bus.ramstore = 32'h1234;
    @(posedge clk); #1;
    total++; if (bus.ramstate !== BUSY) begin bad++; $display("FAIL abort_busy: got=%0d exp=%0d", bus.ramstate, BUSY); end
    bus.ramWEN = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ramstate !== FREE) begin bad++; $display("FAIL abort_free: got=%0d exp=%0d", bus.ramstate, FREE); end
    seen_acc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ramstate !== FREE) seen_acc++;
    end
    total++; if (seen_acc !== 0) begin bad++; $display("FAIL abort_quiet: got=%0d exp=0", seen_acc); end
    run_op(1'b1, 1'b0, 32'h20, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'h0BADF00D) begin bad++; $display("FAIL abort_mem: got=%h exp=0badf00d", ld); end
  endtask

  task automatic test_restart();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    run_op(1'b0, 1'b1, 32'h10, 32'hAAAA0010, nb, fin, ld, aft);
    run_op(1'b0, 1'b1, 32'h14, 32'hBBBB0014, nb, fin, ld, aft);
    bus.ramREN = 1'b1; bus.ramaddr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.ramstate !== BUSY) begin bad++; $display("FAIL rs_pre: got=%0d exp=%0d", bus.ramstate, BUSY); end
    // Address changes during the 2nd BUSY cycle
    run_op(1'b1, 1'b0, 32'h14, 32'h0, nb, fin, ld, aft);
    total++; if (nb !== 2) begin bad++; $display("FAIL rs_busy: got=%0d exp=2", nb); end
    total++; if (fin !== ACCESS) begin bad++; $display("FAIL rs_fin: got=%0d exp=%0d", fin, ACCESS); end
    total++; if (ld !== 32'hBBBB0014) begin bad++; $display("FAIL rs_load: got=%h exp=bbbb0014", ld); end
  endtask

  task automatic test_store_sampling();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    bus.ramWEN = 1'b1; bus.ramaddr = 32'h30; bus.ramstore = 32'h77777777;
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'h30, 32'h88888888, nb, fin, ld, aft);
    total++; if (nb !== 1) begin bad++; $display("FAIL st_busy: got=%0d exp=1", nb); end
    total++; if (fin !== ACCESS) begin bad++; $display("FAIL st_fin: got=%0d exp=%0d", fin, ACCESS); end
    run_op(1'b1, 1'b0, 32'h30, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'h77777777) begin bad++; $display("FAIL st_mem: got=%h exp=77777777", ld); end
  endtask

  task automatic test_back_to_back();
    int nb; logic [1:0] fin, aft; logic [31:0] ld;
    int c0, c1;
    run_op(1'b0, 1'b1, 32'h0, 32'h10203040, nb, fin, ld, aft);
    run_op(1'b0, 1'b1, 32'h4, 32'h50607080, nb, fin, ld, aft);
    c0 = cyc;
    run_op(1'b1, 1'b0, 32'h0, 32'h0, nb, fin, ld, aft);
    c1 = cyc;
    total++; if (ld !== 32'h10203040) begin bad++; $display("FAIL b2b_ld0: got=%h exp=10203040", ld); end
    total++; if (c1 - c0 !== 4) begin bad++; $display("FAIL b2b_space: got=%0d exp=4", c1 - c0); end
    run_op(1'b1, 1'b0, 32'h4, 32'h0, nb, fin, ld, aft);
    total++; if (ld !== 32'h50607080) begin bad++; $display("FAIL b2b_ld4: got=%h exp=50607080", ld); end
    total++; if (nb !== 2) begin bad++; $display("FAIL b2b_busy: got=%0d exp=2", nb); end
  endtask

  task automatic test_lat_builds();
    int nb; logic [1:0] fin; logic [31:0] ld;
    int c0, c1, lat;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 15;
      aux_op(k, 1'b1, 32'h0, 32'hA0000000 + k, nb, fin, ld);
      total++; if (nb !== lat) begin bad++; $display("FAIL lat%0d_wbusy: got=%0d exp=%0d", lat, nb, lat); end
      aux_op(k, 1'b1, 32'h4, 32'hB0000000 + k, nb, fin, ld);
      c0 = cyc;
      aux_op(k, 1'b0, 32'h0, 32'h0, nb, fin, ld);
      c1 = cyc;
      total++; if (nb !== lat) begin bad++; $display("FAIL lat%0d_rbusy: got=%0d exp=%0d", lat, nb, lat); end
      total++; if (fin !== ACCESS) begin bad++; $display("FAIL lat%0d_fin: got=%0d exp=%0d", lat, fin, ACCESS); end
      total++; if (ld !== 32'hA0000000 + k) begin bad++; $display("FAIL lat%0d_ld0: got=%h exp=%h", lat, ld, 32'hA0000000 + k); end
      total++; if (c1 - c0 !== lat + 2) begin bad++; $display("FAIL lat%0d_space: got=%0d exp=%0d", lat, c1 - c0, lat + 2); end
      aux_op(k, 1'b0, 32'h4, 32'h0, nb, fin, ld);
      total++; if (ld !== 32'hB0000000 + k) begin bad++; $display("FAIL lat%0d_ld4: got=%h exp=%h", lat, ld, 32'hB0000000 + k); end
      total++; if (aux_state(k) !== FREE) begin bad++; $display("FAIL lat%0d_after: got=%0d exp=%0d", lat, aux_state(k), FREE); end
    end
  endtask

  initial begin
    bus.ramREN = 1'b0; bus.ramWEN = 1'b0; bus.ramaddr = 32'd0; bus.ramstore = 32'd0;
    for (int k = 0; k < 2; k++) begin
      a_ren[k] = 1'b0; a_wen[k] = 1'b0; a_addr[k] = 32'd0; a_store[k] = 32'd0;
    end
    test_reset();
    test_write_read();
    test_unwritten_and_reset();
    test_errors();
    test_abort();
    test_restart();
    test_store_sampling();
    test_back_to_back();
    test_lat_builds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
